// File: rtl/alu_pipe_if.sv
// Request/response bundle for alu_pipe: operation request in, registered result out.
interface alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opCode;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [3:0]       flags;
    logic             busy;

    modport master (
        output in_valid, opCode, in1, in2, out_ready,
        input  in_ready, out_valid, out, flags, busy
    );

    modport slave (
        input  in_valid, opCode, in1, in2, out_ready,
        output in_ready, out_valid, out, flags, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// Single-issue ALU with a one-cycle result register and a WIDTH-cycle shift-add multiplier.
// state | meaning
// IDLE  | accepting requests; single-cycle ops complete on the accept edge
// MUL   | shift-add multiply in progress, one multiplier bit per cycle
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst,
    alu_pipe_if.slave bus
);
    localparam logic [0:0]     IDLE     = 1'b0;
    localparam logic [0:0]     MUL      = 1'b1;
    localparam logic [3:0]     OP_MUL   = 4'd11;
    localparam logic [3:0]     OP_CMP   = 4'd12;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
    localparam int             M        = WIDTH - 1;

    logic [0:0]         state;
    logic [WIDTH-1:0]   out_r;
    logic [3:0]         flags_r;
    logic               out_valid_r;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;

    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     shl_full;
    logic [WIDTH:0]     shr_full;
    logic [WIDTH:0]     sra_full;
    logic [WIDTH-1:0]   alu_res;
    logic [3:0]         alu_flags;
    logic               c_bit;
    logic               v_bit;
    logic [2*WIDTH-1:0] acc_nxt;
    logic               accept;

    assign a     = bus.in1;
    assign b     = bus.in2;
    assign shamt = bus.in2[SHW-1:0];

    assign bus.in_ready  = !rst && (state == IDLE) && (!out_valid_r || bus.out_ready);
    assign bus.out_valid = out_valid_r;
    assign bus.out       = out_r;
    assign bus.flags     = flags_r;
    assign bus.busy      = (state == MUL);

    assign accept = bus.in_valid && bus.in_ready;

    // Shifts carry one guard bit so the last bit shifted out lands in a fixed position.
    assign sum      = {1'b0, a} + {1'b0, b};
    assign diff     = {1'b0, a} - {1'b0, b};
    assign shl_full = {1'b0, a} << shamt;
    assign shr_full = {a, 1'b0} >> shamt;
    assign sra_full = $unsigned($signed({a, 1'b0}) >>> shamt);

    always_comb begin
        alu_res = '0;
        c_bit   = 1'b0;
        v_bit   = 1'b0;
        case (bus.opCode)
            4'd1: begin
                alu_res = sum[WIDTH-1:0];
                c_bit   = sum[WIDTH];
                v_bit   = (a[M] == b[M]) && (sum[M] != a[M]);
            end
            4'd2, OP_CMP: begin
                alu_res = diff[WIDTH-1:0];
                c_bit   = diff[WIDTH];
                v_bit   = (a[M] != b[M]) && (diff[M] != a[M]);
            end
            4'd3: alu_res = ~a;
            4'd4: alu_res = a & b;
            4'd5: alu_res = a | b;
            4'd6: alu_res = a ^ b;
            4'd7: alu_res = a ~^ b;
            4'd8: begin
                alu_res = shl_full[WIDTH-1:0];
                c_bit   = shl_full[WIDTH];
            end
            4'd9: begin
                alu_res = shr_full[WIDTH:1];
                c_bit   = shr_full[0];
            end
            4'd10: begin
                alu_res = sra_full[WIDTH:1];
                c_bit   = sra_full[0];
            end
            default: ;
        endcase
        alu_flags = {c_bit, v_bit, alu_res[M], alu_res == '0};
        if (bus.opCode == OP_CMP) begin
            alu_flags = {c_bit, v_bit, diff[M], a == b};
            alu_res   = '0;
        end
        if (bus.opCode > OP_CMP) begin
            alu_flags = '0;
        end
    end

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_r       <= '0;
            flags_r     <= '0;
            out_valid_r <= 1'b0;
            mcand       <= '0;
            acc         <= '0;
            mplier      <= '0;
            cnt         <= '0;
        end else if (state == MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == '0) begin
                state       <= IDLE;
                out_r       <= acc_nxt[WIDTH-1:0];
                flags_r     <= {|acc_nxt[2*WIDTH-1:WIDTH], 1'b0, acc_nxt[M],
                                acc_nxt[WIDTH-1:0] == '0};
                out_valid_r <= 1'b1;
            end else begin
                cnt <= cnt - SHW'(1);
            end
        end else if (accept) begin
            if (bus.opCode == OP_MUL) begin
                // Any held result was taken on this edge; nothing is valid until the product lands.
                state       <= MUL;
                mcand       <= {{WIDTH{1'b0}}, a};
                mplier      <= b;
                acc         <= '0;
                cnt         <= CNT_LAST;
                out_valid_r <= 1'b0;
            end else begin
                out_r       <= alu_res;
                flags_r     <= alu_flags;
                out_valid_r <= 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: the driver queues hand-computed results, the monitor checks them.
module tb_alu_pipe;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] o;
        logic [3:0]  f;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] o;
        logic [3:0]  f;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs [0:16];
    int   checks   = 0;
    int   failures = 0;
    int   busy_cnt;
    int   ov_seen;
    bit   rdy_seen;
    longint t_start;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eo, input logic [3:0] ef, input bit push);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.opCode   = op;
        bus.in1      = a;
        bus.in2      = b;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout op%0d actual=in_ready_low required=accept", op);
        end else if (push) begin
            exp_q.push_back('{op, eo, ef});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual out=%h flags=%b required=no_output",
                         bus.out, bus.flags);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("op%0d_result", mon_e.op), {12'h0, bus.out, bus.flags},
                      {12'h0, mon_e.o, mon_e.f});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs = '{
            '{4'd1,  16'hFFFF, 16'h0001, 16'h0000, 4'b1001},
            '{4'd2,  16'h8000, 16'h0001, 16'h7FFF, 4'b0100},
            '{4'd12, 16'h0003, 16'h0005, 16'h0000, 4'b1010},
            '{4'd10, 16'h8010, 16'h0014, 16'hF801, 4'b0010},
            '{4'd8,  16'h8001, 16'h0001, 16'h0002, 4'b1000},
            '{4'd1,  16'h7FFF, 16'h0001, 16'h8000, 4'b0110},
            '{4'd2,  16'h0003, 16'h0005, 16'hFFFE, 4'b1010},
            '{4'd12, 16'h1234, 16'h1234, 16'h0000, 4'b0001},
            '{4'd3,  16'h00F0, 16'h0000, 16'hFF0F, 4'b0010},
            '{4'd5,  16'h00F0, 16'h0F0F, 16'h0FFF, 4'b0000},
            '{4'd7,  16'h00F0, 16'h0F0F, 16'hF000, 4'b0010},
            '{4'd9,  16'h8003, 16'h0011, 16'h4001, 4'b1000},
            '{4'd8,  16'h1234, 16'h0010, 16'h1234, 4'b0000},
            '{4'd10, 16'h0007, 16'h0002, 16'h0001, 4'b1000},
            '{4'd0,  16'h1234, 16'h5678, 16'h0000, 4'b0001},
            '{4'd13, 16'hFFFF, 16'h0001, 16'h0000, 4'b0000},
            '{4'd15, 16'h1234, 16'h0000, 16'h0000, 4'b0000}
        };
        bus.in_valid  = 1'b0;
        bus.opCode    = 4'd0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.out_ready = 1'b1;

        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready_low", {31'h0, bus.in_ready}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("reset_state", {10'h0, bus.out_valid, bus.busy, bus.flags, bus.out}, 32'h0);
        @(posedge clk);
        #1;

        t_start = $time;
        for (int i = 0; i < 17; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].f, 1'b1);
        end
        check("stream_throughput", 32'($time - t_start), 32'd170);
        @(posedge clk);
        #1;

        bus.out_ready = 1'b0;
        issue(4'd1, 16'h1234, 16'h1111, 16'h2345, 4'b0000, 1'b1);
        bus.in_valid = 1'b1;
        bus.opCode   = 4'd4;
        bus.in1      = 16'hF0F0;
        bus.in2      = 16'h3C3C;
        repeat (3) begin
            @(negedge clk);
            check("hold_in_ready_low", {31'h0, bus.in_ready}, 32'h0);
            check("hold_result_stable", {11'h0, bus.out_valid, bus.out, bus.flags},
                  {11'h0, 1'b1, 16'h2345, 4'b0000});
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        issue(4'd4, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000, 1'b1);
        issue(4'd6, 16'hFFFF, 16'h00FF, 16'hFF00, 4'b0010, 1'b1);

        issue(4'd11, 16'h0100, 16'h0101, 16'h0100, 4'b1000, 1'b1);
        busy_cnt = 0;
        rdy_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            busy_cnt++;
            if (bus.in_ready) rdy_seen = 1'b1;
        end
        check("mul_busy_cycles", 32'(busy_cnt), 32'd16);
        check("mul_in_ready_low", {31'h0, rdy_seen}, 32'h0);
        check("mul_out_valid", {31'h0, bus.out_valid}, 32'h1);
        @(posedge clk);
        #1;
        issue(4'd11, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b1000, 1'b1);
        issue(4'd11, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 1'b1);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;

        issue(4'd11, 16'h0100, 16'h0101, 16'h0000, 4'b0000, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_mul_rst_in_ready_low", {31'h0, bus.in_ready}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("post_rst_idle", {30'h0, bus.out_valid, bus.busy}, 32'h0);
        ov_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) ov_seen++;
        end
        check("abandoned_mul_no_output", 32'(ov_seen), 32'h0);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width; power of two, minimum 4.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width taken from in2[SHW-1:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 opCode  input  4  operation select, sampled on accept.
REQ-008 in1  input  WIDTH  operand A, sampled on accept.
REQ-009 in2  input  WIDTH  operand B, sampled on accept.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out  output  WIDTH  registered result.
REQ-013 flags  output  4  registered {carry, ovf, neg, zero}, MSB first.
REQ-014 busy  output  1  high while a multi-cycle multiply is in progress.

Function
REQ-015 Accept happens on an edge where in_valid && in_ready.
REQ-016 in_ready = (state==IDLE) && (!out_valid || out_ready); combinational, no dependency on in_valid.
REQ-017 Opcodes: 0 result 0; 1 A+B; 2 A-B; 3 ~A; 4 A&B; 5 A|B; 6 A^B; 7 A~^B; 8 SHL A by B[SHW-1:0]; 9 logical SHR; 10 arithmetic SHR; 11 MUL low WIDTH bits; 12 CMP (A-B flags, out=0); 13-15 result 0, all flags 0.
REQ-018 Opcodes other than 11: out/flags/out_valid update on the accept edge; latency 1 cycle; throughput 1 per cycle when out_ready held high.
REQ-019 Opcode 11: FSM IDLE->MUL on accept; shift-add one multiplier bit per cycle for WIDTH cycles; MUL->IDLE and out_valid set on the WIDTH-th MUL edge; latency WIDTH+1 edges from accept edge to visible out_valid... counted as out_valid high WIDTH cycles after accept edge.
REQ-020 busy = (state==MUL); in_ready low throughout MUL.
REQ-021 out_valid clears on an edge with out_ready && !accept && state!=completing-MUL; out, flags held stable while out_valid && !out_ready.
REQ-022 Simultaneous out_ready and accept: new result replaces old, out_valid stays 1.
REQ-023 All arithmetic modulo 2^WIDTH; operands unsigned except ovf and opcode 10.
REQ-024 zero = (out==0) except opcode 12, where zero = (A==B); neg = MSB of result (opcode 12: MSB of A-B).
REQ-025 carry: add = carry-out; sub/CMP = borrow (A<B unsigned); shifts = last bit shifted out, 0 when amount 0; MUL = 1 if high half of full product nonzero; else 0.
REQ-026 ovf: add/sub/CMP = signed two's-complement overflow; all other opcodes 0.
REQ-027 Shift amounts use only in2[SHW-1:0]; upper bits of in2 ignored.
REQ-028 rst mid-multiply abandons the operation; no result emitted.

Reset
REQ-029 On rst edge: state=IDLE, out=0, flags=0, out_valid=0, busy=0, multiply datapath registers cleared.
REQ-030 During rst high in_ready=0; in_ready=1 the first cycle after rst deasserts.
REQ-031 rst has priority over every other event, including accept and out_ready.

Verification
REQ-032 WIDTH=16, op1 A=0xFFFF B=0x0001, out_ready=1 -> next cycle out=0x0000, flags carry=1 ovf=0 neg=0 zero=1.
REQ-033 op2 A=0x8000 B=0x0001 -> out=0x7FFF, carry=0, ovf=1, neg=0; op12 A=0x0003 B=0x0005 -> out=0, carry=1, neg=1, zero=0.
REQ-034 op10 A=0x8010 B=0x0014 (amount 4) -> out=0xF801, carry=0; op8 A=0x8001 B=0x0001 -> out=0x0002, carry=1.
REQ-035 op11 A=0x0100 B=0x0101 -> busy 16 cycles, in_ready low, then out=0x0100, carry=1; reissue with rst asserted at cycle 5 -> no out_valid, in_ready=1 after rst.
REQ-036 Back-to-back ops 1,4,6 with out_ready=0 after first -> first result held stable, in_ready=0, second accepted only on the out_ready edge; streaming with out_ready=1 yields one result per cycle.
